spi_mst_seq: RTL and testbench
==============================

# spi_mst_seq

SPI master sequencer that drives the 16-bit command/address/data frame protocol of the SPI slave register port. It converts single-byte host read/write requests on a 12-bit address space into one or two SPI frames. It keeps a shadow of the slave's address register and prefetch state so that sequential accesses cost one frame. It sits between a local host (CPU/DMA glue) and the off-chip or on-chip SPI slave pins.

## Interface
- CLK_DIV, 4: clk cycles per SPI half-period; legal range 4..255; the slave's clock must not be slower than clk.
- CS_GAP, 4: clk cycles with spi_en_n high between frames; minimum 4.
- clk  in  1  system clock; all logic on its rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  host request valid.
- req_ready  out  1  high only in IDLE; a request is accepted on req_valid & req_ready.
- req_wr  in  1  1 = write, 0 = read.
- req_adr  in  12  byte address.
- req_wdata  in  8  write data.
- sh_clr  in  1  pulse; invalidates the shadow address and prefetch state.
- rsp_valid  out  1  one-cycle completion pulse for every request.
- rsp_rdata  out  8  read data, valid with rsp_valid; 8'h00 for writes.
- busy  out  1  high from accept until the rsp_valid cycle, inclusive.
- spi_clk  out  1  SPI clock; idles low.
- spi_en_n  out  1  active-low chip enable.
- spi_mosi  out  1  frame bit, MSB first.
- spi_miso  in  1  slave data.

## Operation
- Frame: 16 bits, MSB first, {cmd[3:0], field[11:0]}.
  - Data frames use field = {4'h0, byte}.
  - Frame 0011 sends field 12'h000.
- Shadow state, cleared by reset and sh_clr: adr_sh[11:0], sh_valid, pf_valid.
  - pf_valid means the slave data register holds mem[adr_sh].
- Write (req_wr=1):
  - If sh_valid & req_adr==adr_sh: one frame, 1011 {4'h0, wdata}.
  - Otherwise: frame 1100 req_adr, then frame 1011.
  - After completion: adr_sh = req_adr+1, sh_valid=1, pf_valid=0.
- Read (req_wr=0):
  - If pf_valid & req_adr==adr_sh: one frame, 0011.
  - Otherwise: frame 1101 req_adr (slave prefetches), then frame 0011.
  - The data byte is the last 8 bits returned by frame 0011.
  - After completion: adr_sh = req_adr+1, sh_valid=1, pf_valid=1.
- adr_sh+1 wraps 12'hFFF -> 12'h000, matching the slave's increment.
- sh_clr while busy: recorded and applied after the completion update, overriding it.
- FSM states: IDLE -> SETUP -> SHIFT -> HOLD -> GAP -> (next frame ? SETUP : DONE) -> IDLE.
  - IDLE: req_ready=1. On accept, latch the request and select the frame list.
  - SETUP: spi_en_n=0, spi_clk=0, mosi=bit15, for CLK_DIV cycles.
  - SHIFT: 16 periods, each CLK_DIV cycles high then CLK_DIV cycles low. mosi advances to the next bit on each falling edge.
  - HOLD: spi_en_n=0, spi_clk=0, for CLK_DIV cycles.
  - GAP: spi_en_n=1 for CS_GAP cycles.
  - DONE: rsp_valid=1 for one cycle, then IDLE.
- MISO capture: sample spi_miso in the last clk cycle of each high phase. Samples from periods 9..16 form rsp_rdata[7:0], MSB first.

## Timing
- Reset values: spi_en_n=1, spi_clk=0, spi_mosi=0, req_ready=0, rsp_valid=0, rsp_rdata=0, busy=0, shadow cleared.
- req_ready rises in the first cycle after rst deasserts.
- rst mid-frame: spi_en_n=1 and spi_clk=0 on the next edge; the slave aborts the partial frame; no rsp_valid.
- Frame length F = 34*CLK_DIV + CS_GAP cycles; 140 at defaults.
- spi_en_n falls the cycle after accept.
- rsp_valid asserts N*F+1 cycles after the accept cycle, N = 1 or 2; 141 or 281 at defaults.
- req_valid while busy is ignored; no request queueing.
- rsp_valid and req_ready are never high in the same cycle; the next accept is possible the cycle after rsp_valid.

## Test plan
- Reset, then write 0x3A to 0x123 -> frames 0xC123 then 0xB03A; rsp_valid at cycle 281; adr_sh=0x124.
- Write 0x55 to 0x124 immediately after -> single frame 0xB055; rsp_valid at 141.
- Read 0x200 from a slave model with mem[0x200]=0xA5 -> frames 0xD200 then 0x3000; rsp_rdata=0xA5. A following read of 0x201 (mem=0x5A) -> single frame 0x3000; rsp_rdata=0x5A.
- Write to 0xFFF, then write to 0x000 -> second write is a single frame (wrap). Read 0x000 afterwards -> two frames, since pf_valid=0 after a write.
- sh_clr pulsed mid-transaction, then a sequential read -> two frames issued. Second sub-case: assert rst during SHIFT bit 7 -> spi_en_n=1 next cycle, no rsp_valid, the next request uses the full two-frame sequence.
- CLK_DIV=4 with a slave clocked at clk -> every bit exact. Randomized req_valid during busy -> never accepted.

Source files
------------

// File: rtl/spi_mst_seq.sv
// spi_mst_seq: SPI master sequencer for 16-bit cmd/address/data frames.
// It turns one-byte host reads/writes on a 12-bit address space into one or
// two SPI frames. A shadow of the slave's address pointer and prefetch state
// lets sequential accesses use a single frame.
// Ports:
//   clk, rst          system clock, synchronous active-high reset
//   req_valid/ready   host request handshake
//   req_wr            1 = write, 0 = read
//   req_adr           12-bit byte address
//   req_wdata         8-bit write data
//   sh_clr            pulse that invalidates the shadow state
//   rsp_valid         one-cycle completion pulse
//   rsp_rdata         read data (8'h00 for writes)
//   busy              high from accept through the rsp_valid cycle
//   spi_clk           SPI clock, idles low
//   spi_en_n          active-low chip enable
//   spi_mosi          frame bit out, MSB first
//   spi_miso          slave data in
module spi_mst_seq #(
   parameter int CLK_DIV = 4,
   parameter int CS_GAP  = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_wr,
   input  logic [11:0] req_adr,
   input  logic [7:0]  req_wdata,
   input  logic        sh_clr,
   output logic        rsp_valid,
   output logic [7:0]  rsp_rdata,
   output logic        busy,
   output logic        spi_clk,
   output logic        spi_en_n,
   output logic        spi_mosi,
   input  logic        spi_miso
);

   localparam logic [15:0] DIV_M1 = 16'(CLK_DIV - 1);
   localparam logic [15:0] GAP_M1 = 16'(CS_GAP - 1);

   typedef enum logic [2:0] {
      IDLE, SETUP, SHIFT, HOLD, GAP, DONE
   } state_t;

   state_t      state;
   state_t      state_nx;
   logic [15:0] cnt;
   logic [3:0]  bit_cnt;
   logic        hi;
   logic        wr_q;
   logic [11:0] adr_q;
   logic [7:0]  wdata_q;
   logic        first;
   logic [15:0] sreg;
   logic [7:0]  rx;
   logic [7:0]  rdata_q;
   logic [11:0] adr_sh;
   logic        sh_valid;
   logic        pf_valid;
   logic        clr_pend;

   logic        accept;
   logic        hit;
   logic        div_end;
   logic        gap_end;
   logic        restart;
   logic [15:0] frame_lo;
   logic [15:0] req_lo;
   logic [15:0] req_hi;

   assign accept  = req_valid & req_ready;
   assign div_end = (cnt == DIV_M1);
   assign gap_end = (cnt == GAP_M1);

   // A shadow clear arriving with the request forces the long sequence.
   assign hit = ~sh_clr & (req_adr == adr_sh) &
                (req_wr ? sh_valid : pf_valid);

   assign frame_lo = wr_q ? {8'hB0, wdata_q} : 16'h3000;
   assign req_lo   = req_wr ? {8'hB0, req_wdata} : 16'h3000;
   assign req_hi   = {(req_wr ? 4'hC : 4'hD), req_adr};

   // Counter restarts on every state change and every SPI half-period.
   assign restart = (state_nx != state) | ((state == SHIFT) & div_end);

   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE:    if (accept) state_nx = SETUP;
         SETUP:   if (div_end) state_nx = SHIFT;
         SHIFT:   if (div_end & ~hi & (bit_cnt == 4'd15)) state_nx = HOLD;
         HOLD:    if (div_end) state_nx = GAP;
         GAP:     if (gap_end) state_nx = first ? SETUP : DONE;
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_comb begin
      req_ready = (state == IDLE) & ~rst;
      rsp_valid = (state == DONE);
      busy      = (state != IDLE) | accept;
      spi_en_n  = ~((state == SETUP) | (state == SHIFT) | (state == HOLD));
      spi_clk   = (state == SHIFT) & hi;
      spi_mosi  = ~spi_en_n & sreg[15];
      rsp_rdata = rdata_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         cnt      <= '0;
         bit_cnt  <= '0;
         hi       <= 1'b1;
         wr_q     <= 1'b0;
         adr_q    <= '0;
         wdata_q  <= '0;
         first    <= 1'b0;
         sreg     <= '0;
         rx       <= '0;
         rdata_q  <= '0;
         adr_sh   <= '0;
         sh_valid <= 1'b0;
         pf_valid <= 1'b0;
         clr_pend <= 1'b0;
      end else begin
         state <= state_nx;
         cnt   <= restart ? '0 : cnt + 16'd1;

         if (state == IDLE && accept) begin
            wr_q    <= req_wr;
            adr_q   <= req_adr;
            wdata_q <= req_wdata;
            first   <= ~hit;
            sreg    <= hit ? req_lo : req_hi;
         end

         if (state == SETUP) begin
            hi      <= 1'b1;
            bit_cnt <= '0;
         end

         if (state == SHIFT && div_end) begin
            hi <= ~hi;
            if (hi) begin
               sreg <= {sreg[14:0], 1'b0};
               rx   <= {rx[6:0], spi_miso};
            end else begin
               bit_cnt <= bit_cnt + 4'd1;
            end
         end

         if (state == GAP && gap_end) begin
            if (first) begin
               first <= 1'b0;
               sreg  <= frame_lo;
            end else begin
               rdata_q <= wr_q ? 8'h00 : rx;
            end
         end

         // A clear seen while busy wins over the completion update.
         if (state == DONE) begin
            clr_pend <= 1'b0;
            if (clr_pend | sh_clr) begin
               adr_sh   <= '0;
               sh_valid <= 1'b0;
               pf_valid <= 1'b0;
            end else begin
               adr_sh   <= adr_q + 12'd1;
               sh_valid <= 1'b1;
               pf_valid <= ~wr_q;
            end
         end else if (sh_clr) begin
            if (state == IDLE) begin
               adr_sh   <= '0;
               sh_valid <= 1'b0;
               pf_valid <= 1'b0;
            end else begin
               clr_pend <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_spi_mst_seq.sv
// tb_spi_mst_seq: bench for spi_mst_seq with a clk-rate SPI slave model
// and frame/response scoreboards.
module tb_spi_mst_seq;

   localparam int CLK_DIV = 4;
   localparam int CS_GAP  = 4;
   localparam int F       = 34 * CLK_DIV + CS_GAP;
   localparam int EN_LEN  = 34 * CLK_DIV;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_wr = 1'b0;
   logic [11:0] req_adr = '0;
   logic [7:0]  req_wdata = '0;
   logic        sh_clr = 1'b0;
   logic        rsp_valid;
   logic [7:0]  rsp_rdata;
   logic        busy;
   logic        spi_clk;
   logic        spi_en_n;
   logic        spi_mosi;
   logic        spi_miso;

   int tests = 0;
   int fails = 0;
   int cyc = 0;
   int acc_cnt = 0;
   int both_hi = 0;

   logic [15:0] exp_frm[$];
   logic [15:0] obs_frm[$];
   int          obs_len[$];
   int          exp_lat[$];
   logic [7:0]  exp_rd[$];
   int          obs_lat[$];
   logic [7:0]  obs_rd[$];
   bit          obs_bz[$];

   spi_mst_seq #(.CLK_DIV(CLK_DIV), .CS_GAP(CS_GAP)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_wr(req_wr), .req_adr(req_adr), .req_wdata(req_wdata),
      .sh_clr(sh_clr),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .busy(busy),
      .spi_clk(spi_clk), .spi_en_n(spi_en_n),
      .spi_mosi(spi_mosi), .spi_miso(spi_miso)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (req_valid && req_ready) acc_cnt <= acc_cnt + 1;
      if (rsp_valid && req_ready) both_hi <= both_hi + 1;
   end

   // Slave register port model running on clk.
   logic [7:0]  mem [4096];
   logic [11:0] s_adr = '0;
   logic [7:0]  s_dat = '0;
   logic [15:0] s_rx = '0;
   logic [15:0] s_tx = '0;
   int          s_bits = 0;
   int          en_cnt = 0;
   logic        p_clk = 1'b0;
   logic        p_en = 1'b1;

   assign spi_miso = s_tx[15];

   always @(posedge clk) begin
      p_clk <= spi_clk;
      p_en  <= spi_en_n;
      if (spi_en_n) begin
         if (!p_en && s_bits == 16) begin
            obs_frm.push_back(s_rx);
            obs_len.push_back(en_cnt);
            case (s_rx[15:12])
               4'hC: s_adr <= s_rx[11:0];
               4'hD: begin
                  s_adr <= s_rx[11:0];
                  s_dat <= mem[s_rx[11:0]];
               end
               4'h3: begin
                  s_adr <= s_adr + 12'd1;
                  s_dat <= mem[s_adr + 12'd1];
               end
               4'hB: begin
                  mem[s_adr] <= s_rx[7:0];
                  s_adr <= s_adr + 12'd1;
               end
               default: ;
            endcase
         end
         s_bits <= 0;
      end else begin
         if (p_en) begin
            s_tx   <= {8'h00, s_dat};
            en_cnt <= 1;
         end else begin
            en_cnt <= en_cnt + 1;
            if (p_clk && !spi_clk) s_tx <= {s_tx[14:0], 1'b0};
         end
         if (!p_clk && spi_clk) begin
            s_rx   <= {s_rx[14:0], spi_mosi};
            s_bits <= s_bits + 1;
         end
      end
   end

   task automatic run_req(input logic wr, input logic [11:0] adr,
                          input logic [7:0] wd);
      int t0;
      int n;
      bit bz_bad;
      @(negedge clk);
      req_valid = 1'b1;
      req_wr    = wr;
      req_adr   = adr;
      req_wdata = wd;
      n = 0;
      while (!req_ready && n < 1000) begin
         @(negedge clk);
         n++;
      end
      t0 = cyc;
      bz_bad = 1'b0;
      @(negedge clk);
      req_valid = 1'b0;
      n = 0;
      while (!rsp_valid && n < 2000) begin
         if (!busy) bz_bad = 1'b1;
         @(negedge clk);
         n++;
      end
      if (!busy) bz_bad = 1'b1;
      obs_lat.push_back(rsp_valid ? cyc - t0 : -1);
      obs_rd.push_back(rsp_rdata);
      obs_bz.push_back(bz_bad);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      tests++;
      if ({spi_en_n, spi_clk, spi_mosi, req_ready, rsp_valid, busy} !== 6'b100000
          || rsp_rdata !== 8'h00) begin
         fails++;
         $display("FAIL reset_outputs: got en_n=%b clk=%b mosi=%b rdy=%b rsp=%b busy=%b rd=%h, want 1 0 0 0 0 0 00",
                  spi_en_n, spi_clk, spi_mosi, req_ready, rsp_valid, busy, rsp_rdata);
      end
      rst = 1'b0;
      @(negedge clk);
      tests++;
      if (req_ready !== 1'b1) begin
         fails++;
         $display("FAIL reset_ready: got %b want 1", req_ready);
      end
   endtask

   task automatic test_write();
      logic [15:0] f;
      logic [15:0] o;
      int          ln;
      exp_frm.push_back(16'hC123);
      exp_frm.push_back(16'hB03A);
      exp_lat.push_back(2 * F + 1);
      exp_rd.push_back(8'h00);
      run_req(1'b1, 12'h123, 8'h3A);
      exp_frm.push_back(16'hB055);
      exp_lat.push_back(F + 1);
      exp_rd.push_back(8'h00);
      run_req(1'b1, 12'h124, 8'h55);
      while (exp_frm.size() > 0) begin
         f  = exp_frm.pop_front();
         o  = (obs_frm.size() > 0) ? obs_frm.pop_front() : 16'hxxxx;
         ln = (obs_len.size() > 0) ? obs_len.pop_front() : -1;
         tests++;
         if (o !== f || ln != EN_LEN) begin
            fails++;
            $display("FAIL write_frame: got %h len %0d, want %h len %0d", o, ln, f, EN_LEN);
         end
      end
      while (exp_lat.size() > 0) begin
         tests++;
         if (obs_lat.pop_front() != exp_lat[0] || obs_rd.pop_front() !== exp_rd[0]
             || obs_bz.pop_front()) begin
            fails++;
            $display("FAIL write_rsp: latency/rdata/busy wrong, want lat %0d rd %h", exp_lat[0], exp_rd[0]);
         end
         void'(exp_lat.pop_front());
         void'(exp_rd.pop_front());
      end
      tests++;
      if (obs_frm.size() != 0 || mem[12'h123] !== 8'h3A || mem[12'h124] !== 8'h55) begin
         fails++;
         $display("FAIL write_mem: extra %0d frames, mem123=%h mem124=%h, want 0 3a 55",
                  obs_frm.size(), mem[12'h123], mem[12'h124]);
      end
   endtask

   task automatic test_read();
      logic [15:0] f;
      logic [15:0] o;
      int          ln;
      mem[12'h200] = 8'hA5;
      mem[12'h201] = 8'h5A;
      exp_frm.push_back(16'hD200);
      exp_frm.push_back(16'h3000);
      exp_lat.push_back(2 * F + 1);
      exp_rd.push_back(8'hA5);
      run_req(1'b0, 12'h200, 8'h00);
      exp_frm.push_back(16'h3000);
      exp_lat.push_back(F + 1);
      exp_rd.push_back(8'h5A);
      run_req(1'b0, 12'h201, 8'h00);
      while (exp_frm.size() > 0) begin
         f  = exp_frm.pop_front();
         o  = (obs_frm.size() > 0) ? obs_frm.pop_front() : 16'hxxxx;
         ln = (obs_len.size() > 0) ? obs_len.pop_front() : -1;
         tests++;
         if (o !== f || ln != EN_LEN) begin
            fails++;
            $display("FAIL read_frame: got %h len %0d, want %h len %0d", o, ln, f, EN_LEN);
         end
      end
      while (exp_lat.size() > 0) begin
         int       l;
         logic [7:0] r;
         bit       b;
         l = obs_lat.pop_front();
         r = obs_rd.pop_front();
         b = obs_bz.pop_front();
         tests++;
         if (l != exp_lat[0] || r !== exp_rd[0] || b) begin
            fails++;
            $display("FAIL read_rsp: got lat %0d rd %h busy_drop %0d, want lat %0d rd %h",
                     l, r, b, exp_lat[0], exp_rd[0]);
         end
         void'(exp_lat.pop_front());
         void'(exp_rd.pop_front());
      end
   endtask

   task automatic test_wrap();
      logic [15:0] f;
      logic [15:0] o;
      exp_frm.push_back(16'hCFFF);
      exp_frm.push_back(16'hB011);
      exp_lat.push_back(2 * F + 1);
      exp_rd.push_back(8'h00);
      run_req(1'b1, 12'hFFF, 8'h11);
      exp_frm.push_back(16'hB022);
      exp_lat.push_back(F + 1);
      exp_rd.push_back(8'h00);
      run_req(1'b1, 12'h000, 8'h22);
      exp_frm.push_back(16'hD000);
      exp_frm.push_back(16'h3000);
      exp_lat.push_back(2 * F + 1);
      exp_rd.push_back(8'h22);
      run_req(1'b0, 12'h000, 8'h00);
      while (exp_frm.size() > 0) begin
         f = exp_frm.pop_front();
         o = (obs_frm.size() > 0) ? obs_frm.pop_front() : 16'hxxxx;
         if (obs_len.size() > 0) void'(obs_len.pop_front());
         tests++;
         if (o !== f) begin
            fails++;
            $display("FAIL wrap_frame: got %h want %h", o, f);
         end
      end
      while (exp_lat.size() > 0) begin
         int       l;
         logic [7:0] r;
         l = obs_lat.pop_front();
         r = obs_rd.pop_front();
         void'(obs_bz.pop_front());
         tests++;
         if (l != exp_lat[0] || r !== exp_rd[0]) begin
            fails++;
            $display("FAIL wrap_rsp: got lat %0d rd %h, want lat %0d rd %h",
                     l, r, exp_lat[0], exp_rd[0]);
         end
         void'(exp_lat.pop_front());
         void'(exp_rd.pop_front());
      end
   endtask

   task automatic test_sh_clr();
      logic [15:0] f;
      logic [15:0] o;
      mem[12'h300] = 8'h77;
      mem[12'h301] = 8'h88;
      exp_frm.push_back(16'hD300);
      exp_frm.push_back(16'h3000);
      exp_rd.push_back(8'h77);
      exp_frm.push_back(16'hD301);
      exp_frm.push_back(16'h3000);
      exp_rd.push_back(8'h88);
      fork
         run_req(1'b0, 12'h300, 8'h00);
         begin
            repeat (50) @(negedge clk);
            sh_clr = 1'b1;
            @(negedge clk);
            sh_clr = 1'b0;
         end
      join
      run_req(1'b0, 12'h301, 8'h00);
      while (exp_frm.size() > 0) begin
         f = exp_frm.pop_front();
         o = (obs_frm.size() > 0) ? obs_frm.pop_front() : 16'hxxxx;
         if (obs_len.size() > 0) void'(obs_len.pop_front());
         tests++;
         if (o !== f) begin
            fails++;
            $display("FAIL shclr_frame: got %h want %h", o, f);
         end
      end
      while (exp_rd.size() > 0) begin
         logic [7:0] r;
         r = obs_rd.pop_front();
         void'(obs_lat.pop_front());
         void'(obs_bz.pop_front());
         tests++;
         if (r !== exp_rd[0]) begin
            fails++;
            $display("FAIL shclr_rdata: got %h want %h", r, exp_rd[0]);
         end
         void'(exp_rd.pop_front());
      end
   endtask

   task automatic test_rst_mid();
      int nrsp;
      logic [15:0] f;
      logic [15:0] o;
      mem[12'h302] = 8'hC3;
      @(negedge clk);
      req_valid = 1'b1;
      req_wr    = 1'b0;
      req_adr   = 12'h302;
      @(negedge clk);
      req_valid = 1'b0;
      repeat (60) @(negedge clk);
      tests++;
      if (spi_clk !== 1'b1 || spi_en_n !== 1'b0) begin
         fails++;
         $display("FAIL rst_mid_inframe: got clk %b en_n %b want 1 0", spi_clk, spi_en_n);
      end
      rst = 1'b1;
      @(negedge clk);
      tests++;
      if (spi_en_n !== 1'b1 || spi_clk !== 1'b0) begin
         fails++;
         $display("FAIL rst_mid_abort: got en_n %b clk %b want 1 0", spi_en_n, spi_clk);
      end
      rst = 1'b0;
      nrsp = 0;
      repeat (300) begin
         @(negedge clk);
         if (rsp_valid) nrsp++;
      end
      tests++;
      if (nrsp != 0 || obs_frm.size() != 0) begin
         fails++;
         $display("FAIL rst_mid_norsp: got %0d rsp %0d frames want 0 0", nrsp, obs_frm.size());
      end
      exp_frm.push_back(16'hD302);
      exp_frm.push_back(16'h3000);
      run_req(1'b0, 12'h302, 8'h00);
      while (exp_frm.size() > 0) begin
         f = exp_frm.pop_front();
         o = (obs_frm.size() > 0) ? obs_frm.pop_front() : 16'hxxxx;
         if (obs_len.size() > 0) void'(obs_len.pop_front());
         tests++;
         if (o !== f) begin
            fails++;
            $display("FAIL rst_mid_frame: got %h want %h", o, f);
         end
      end
      tests++;
      if (obs_rd[0] !== 8'hC3 || obs_lat[0] != 2 * F + 1) begin
         fails++;
         $display("FAIL rst_mid_rsp: got rd %h lat %0d want c3 %0d", obs_rd[0], obs_lat[0], 2 * F + 1);
      end
      obs_rd.delete();
      obs_lat.delete();
      obs_bz.delete();
   endtask

   task automatic test_busy_ignore();
      int a0;
      int t0;
      int n;
      logic [15:0] f;
      logic [15:0] o;
      exp_frm.push_back(16'hC400);
      exp_frm.push_back(16'hB099);
      exp_frm.push_back(16'hD400);
      exp_frm.push_back(16'h3000);
      a0 = acc_cnt;
      @(negedge clk);
      req_valid = 1'b1;
      req_wr    = 1'b1;
      req_adr   = 12'h400;
      req_wdata = 8'h99;
      t0 = cyc;
      @(negedge clk);
      n = 0;
      while (!rsp_valid && n < 2000) begin
         req_valid = 1'($urandom_range(0, 1));
         req_wr    = 1'($urandom_range(0, 1));
         req_adr   = 12'($urandom);
         req_wdata = 8'($urandom);
         @(negedge clk);
         n++;
      end
      req_valid = 1'b0;
      tests++;
      if (!rsp_valid || cyc - t0 != 2 * F + 1 || acc_cnt - a0 != 1) begin
         fails++;
         $display("FAIL busy_ignore: got lat %0d accepts %0d want %0d 1",
                  cyc - t0, acc_cnt - a0, 2 * F + 1);
      end
      run_req(1'b0, 12'h400, 8'h00);
      tests++;
      if (obs_rd[0] !== 8'h99) begin
         fails++;
         $display("FAIL busy_readback: got %h want 99", obs_rd[0]);
      end
      obs_rd.delete();
      obs_lat.delete();
      obs_bz.delete();
      while (exp_frm.size() > 0) begin
         f = exp_frm.pop_front();
         o = (obs_frm.size() > 0) ? obs_frm.pop_front() : 16'hxxxx;
         if (obs_len.size() > 0) void'(obs_len.pop_front());
         tests++;
         if (o !== f) begin
            fails++;
            $display("FAIL busy_frame: got %h want %h", o, f);
         end
      end
      tests++;
      if (obs_frm.size() != 0 || both_hi != 0) begin
         fails++;
         $display("FAIL busy_extra: got %0d extra frames, %0d rsp&ready cycles, want 0 0",
                  obs_frm.size(), both_hi);
      end
   endtask

   initial begin
      for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
      test_reset();
      test_write();
      test_read();
      test_wrap();
      test_sh_clr();
      test_rst_mid();
      test_busy_ignore();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #900000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

endmodule
